// File: rtl/tick_period_meter.sv
// tick_period_meter: measures the clk-cycle interval between rising edges
// of a (possibly asynchronous) tick line, single-shot or continuous.
// Ports: clk, rst (async, active-high), i_start, i_clear, i_event_in,
//        o_period, o_period_stb, o_valid, o_overflow, o_busy.
module tick_period_meter #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CONTINUOUS  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic             i_event_in,
  output logic [WIDTH-1:0] o_period,
  output logic             o_period_stb,
  output logic             o_valid,
  output logic             o_overflow,
  output logic             o_busy
);

  localparam logic [WIDTH-1:0] LP_MAX =
    {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] LP_MAX_M1 =
    {{(WIDTH-1){1'b1}}, 1'b0};
  localparam bit LP_CONT = (CONTINUOUS != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_MEAS,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_edge;
  logic [WIDTH-1:0]       r_count;
  logic [WIDTH-1:0]       w_count;
  logic [WIDTH-1:0]       r_period;
  logic [WIDTH-1:0]       w_period;
  logic                   r_stb;
  logic                   w_stb;
  logic                   r_valid;
  logic                   w_valid;
  logic                   r_ovf;
  logic                   w_ovf;
  logic                   r_busy;
  logic                   w_busy;

  // Synchroniser chain plus one "prev" flop for rising-edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_event_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_period <= '0;
      r_stb    <= 1'b0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_count  <= w_count;
      r_period <= w_period;
      r_stb    <= w_stb;
      r_valid  <= w_valid;
      r_ovf    <= w_ovf;
      r_busy   <= w_busy;
    end
  end

  // clear beats start; start beats a closing edge.
  always_comb begin
    w_next   = r_state;
    w_count  = r_count;
    w_period = r_period;
    w_stb    = 1'b0;
    w_valid  = r_valid;
    w_ovf    = r_ovf;
    if (i_clear) begin
      w_next  = S_IDLE;
      w_valid = 1'b0;
      w_ovf   = 1'b0;
    end else if (i_start) begin
      w_next  = S_ARMED;
      w_valid = 1'b0;
      w_ovf   = 1'b0;
    end else begin
      unique case (r_state)
        S_ARMED: begin
          if (w_edge) begin
            w_count = '0;
            w_next  = S_MEAS;
          end
        end
        S_MEAS: begin
          if (w_edge) begin
            // counter holds N-1 when the edge N cycles later arrives
            w_period = r_count + 1'b1;
            w_valid  = 1'b1;
            w_ovf    = 1'b0;
            w_stb    = 1'b1;
            if (LP_CONT) begin
              w_count = '0;
            end else begin
              w_next = S_DONE;
            end
          end else if (r_count == LP_MAX_M1) begin
            w_period = LP_MAX;
            w_valid  = 1'b1;
            w_ovf    = 1'b1;
            w_stb    = 1'b1;
            w_next   = LP_CONT ? S_ARMED : S_DONE;
          end else begin
            w_count = r_count + 1'b1;
          end
        end
        S_IDLE: begin
        end
        S_DONE: begin
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
    w_busy = (w_next == S_ARMED) ||
             (w_next == S_MEAS);
  end

  assign o_period     = r_period;
  assign o_period_stb = r_stb;
  assign o_valid      = r_valid;
  assign o_overflow   = r_ovf;
  assign o_busy       = r_busy;

endmodule

// File: doc/tick_period_meter.md
Name: tick_period_meter

Overview:
- Receiving end of the periodic tick interface driven by the team's counter timers: measures the interval between consecutive rising edges of an incoming tick/event line, in clk cycles.
- The input may be asynchronous to clk (for example, a tick from another clock domain or an external pin), so it is synchronised internally.
- Used to check timer divisors and to measure external pulse periods.
- Single-shot or continuous operation; saturating overflow flag.

Parameters:
- WIDTH, 16, width of the period counter and result; MAX = 2^WIDTH-1.
- SYNC_STAGES, 2, flip-flop stages in the event_in synchroniser; legal values are 2 or more.
- CONTINUOUS, 0, 0 = single-shot (stop after one result); 1 = re-arm automatically, where each closing edge also opens the next interval.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; arms a measurement and discards any result.
- clear  in  1  synchronous abort to IDLE; clears valid and overflow.
- event_in  in  1  tick/event line, possibly asynchronous.
- period  out  WIDTH  last measured interval in clk cycles; MAX on overflow.
- period_stb  out  1  one-cycle pulse when period/overflow are updated.
- valid  out  1  sticky: a result is held.
- overflow  out  1  sticky: the last result saturated.
- busy  out  1  high in ARMED or MEASURE.

Behaviour:
- Reset (async): state IDLE, counter 0, period 0, period_stb 0, valid 0, overflow 0, busy 0. The synchroniser and edge register also reset to 0.
- Edge detect: event_in passes through SYNC_STAGES flops, then one more "prev" flop.
  - edge = sync_out & ~prev.
  - A rising event_in edge gives edge high SYNC_STAGES+1 cycles later (3 cycles for the default).
  - Event pulses narrower than one clk period may be missed; this is permitted.
- IDLE:
  - start -> ARMED.
  - Edges are ignored.
- ARMED (waiting for the first edge):
  - edge -> counter <= 0, go to MEASURE.
- MEASURE: let the opening edge be at cycle t. The counter holds k-1 at cycle t+k.
  - edge at cycle t+N: period <= counter+1 (= N), valid <= 1, overflow <= 0, period_stb pulses. Next state is DONE if CONTINUOUS=0. If CONTINUOUS=1, set counter <= 0 and stay in MEASURE; this edge opens the next interval.
  - No edge and counter == MAX-1: period <= MAX, overflow <= 1, valid <= 1, period_stb pulses. Next state is DONE if CONTINUOUS=0, or ARMED if CONTINUOUS=1.
  - Otherwise: counter <= counter+1.
  - The counter never wraps.
- DONE:
  - Holds period, valid and overflow.
  - start -> ARMED (valid and overflow cleared).
  - Edges are ignored.
- start in any state (including mid-measurement) -> ARMED next cycle; valid and overflow cleared; period keeps its old value.
- clear in any state -> IDLE; valid and overflow cleared; period keeps its old value.
- clear and start in the same cycle: clear wins.
- start on the same cycle as a closing edge: start wins and no result is posted.
- Counter and period arithmetic is unsigned, WIDTH bits.
- busy is a registered decode of the state.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst mid-MEASURE -> all outputs 0 immediately (async), state IDLE; after release, edges are ignored until start.
- Single-shot, WIDTH=16: start, then event_in rising edges 100 clk apart -> one period_stb, period=100, valid=1, overflow=0, busy=0; a third edge leaves outputs unchanged.
- Continuous: CONTINUOUS=1, edges every 37 cycles for 5 intervals -> period_stb every 37 cycles, each period=37.
- Continuous variable spacing: intervals 10, 11, 3 -> periods 10, 11, 3.
- Overflow: WIDTH=8, one edge and no second edge -> 255 cycles after the opening edge, period=255, overflow=1, valid=1.
  - A second edge exactly 255 cycles after the first -> period=255, overflow=0.
- Abort and priority:
  - start mid-MEASURE -> returns to ARMED; the next two edges 20 apart give period=20.
  - start+clear in the same cycle -> IDLE, valid=0.
  - Asynchronous event_in with jitter relative to clk -> result within ±1 of the nominal period.
